// File: rtl/fraction_divider4_if.sv
// Start/complete handshake and data bus of the Q1.6 / Q1.3 fraction divider.
interface fraction_divider4_if;
    logic       St;
    logic [6:0] Dividend;
    logic [3:0] Divisor;
    logic [3:0] Quotient;
    logic [3:0] Remainder;
    logic       V;
    logic       Done;

    modport master (output St, Dividend, Divisor, input Quotient, Remainder, V, Done);
    modport slave  (input St, Dividend, Divisor, output Quotient, Remainder, V, Done);
endinterface

// File: rtl/fraction_divider4.sv
// Sequential sign-magnitude restoring divider: Q1.6 dividend / Q1.3 divisor -> Q1.3 quotient.
// Define FRAC_DIV_ROUND_EN to round the quotient magnitude half away from zero.
module fraction_divider4 (
    input logic             CLK,
    input logic             RST_N,
    fraction_divider4_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
        S_SIGN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     state;
    logic [6:0] dvd_q;
    logic [3:0] dvs_q;
    logic [6:0] r_mag;
    logic [3:0] d_mag;
    logic [2:0] q_mag;
    logic [1:0] cnt;
    logic       sq;
    logic       sr;
    logic [3:0] quot_r;
    logic [3:0] rem_r;
    logic       v_r;
    logic       done_r;

    logic [6:0] abs_dvd;
    logic [3:0] abs_dvs;
    logic       ovf;
    logic [6:0] trial;
    logic       ge;
    logic [2:0] q_fin;
    logic [3:0] quot_mag;
    logic [3:0] rem_mag;
    logic [3:0] quot_sgn;
    logic [3:0] rem_sgn;

    // Magnitudes fit unsigned: -1.0 maps to 64 (dividend) and 8 (divisor).
    always_comb begin
        abs_dvd = dvd_q[6] ? (7'd0 - dvd_q) : dvd_q;
        abs_dvs = dvs_q[3] ? (4'd0 - dvs_q) : dvs_q;
        ovf     = (abs_dvs == 4'd0) || ({1'b0, abs_dvd} >= {1'b0, abs_dvs, 3'b000});
    end

    always_comb begin
        trial = {3'b000, d_mag} << cnt;
        ge    = (r_mag >= trial);
    end

    // Final R < d <= 8, so R[3:0] is enough for the half-way test and R[2:0] for the output.
    always_comb begin
`ifdef FRAC_DIV_ROUND_EN
        if (({r_mag[3:0], 1'b0} >= {1'b0, d_mag}) && (q_mag != 3'b111))
            q_fin = q_mag + 3'd1;
        else
            q_fin = q_mag;
`else
        q_fin = q_mag;
`endif
        quot_mag = {1'b0, q_fin};
        rem_mag  = {1'b0, r_mag[2:0]};
        quot_sgn = sq ? (4'd0 - quot_mag) : quot_mag;
        rem_sgn  = sr ? (4'd0 - rem_mag) : rem_mag;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            dvd_q  <= '0;
            dvs_q  <= '0;
            r_mag  <= '0;
            d_mag  <= '0;
            q_mag  <= '0;
            cnt    <= '0;
            sq     <= 1'b0;
            sr     <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            v_r    <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.St) begin
                        dvd_q <= bus.Dividend;
                        dvs_q <= bus.Divisor;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sq    <= dvd_q[6] ^ dvs_q[3];
                    sr    <= dvd_q[6];
                    d_mag <= abs_dvs;
                    if (ovf) begin
                        v_r    <= 1'b1;
                        quot_r <= (dvd_q[6] ^ dvs_q[3]) ? 4'b1000 : 4'b0111;
                        rem_r  <= 4'b0000;
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        r_mag <= abs_dvd;
                        q_mag <= 3'b000;
                        cnt   <= 2'd2;
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    // Quotient bits arrive MSB first, so shifting left places bit i correctly.
                    q_mag <= {q_mag[1:0], ge};
                    if (ge)
                        r_mag <= r_mag - trial;
                    if (cnt == 2'd0)
                        state <= S_SIGN;
                    else
                        cnt <= cnt - 2'd1;
                end
                S_SIGN: begin
                    quot_r <= quot_sgn;
                    rem_r  <= rem_sgn;
                    v_r    <= 1'b0;
                    done_r <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Quotient  = quot_r;
    assign bus.Remainder = rem_r;
    assign bus.V         = v_r;
    assign bus.Done      = done_r;

endmodule

// File: tb/tb_fraction_divider4.sv
// Directed + random scoreboard bench for fraction_divider4 (both rounding builds).
module tb_fraction_divider4;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   tests = 0;
    int   fails = 0;

    fraction_divider4_if bus ();

    fraction_divider4 dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       v;
        int         lat;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [6:0] dvd, input logic [3:0] dvs);
        exp_t e;
        int a, b, dd, d, qm, rm;
        a  = int'($signed(dvd));
        b  = int'($signed(dvs));
        dd = (a < 0) ? -a : a;
        d  = (b < 0) ? -b : b;
        if (d == 0 || dd >= 8 * d) begin
            e.v   = 1'b1;
            e.q   = ((a < 0) != (b < 0)) ? 4'b1000 : 4'b0111;
            e.r   = 4'b0000;
            e.lat = 2;
        end else begin
            qm = dd / d;
            rm = dd % d;
`ifdef FRAC_DIV_ROUND_EN
            if (2 * rm >= d && qm != 7) qm = qm + 1;
`endif
            e.v   = 1'b0;
            e.q   = ((a < 0) != (b < 0)) ? 4'(-qm) : 4'(qm);
            e.r   = (a < 0) ? 4'(-rm) : 4'(rm);
            e.lat = 6;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at the negedge of cycle 1 after the St edge; returns at the negedge where Done is seen.
    task automatic wait_check(input string tag);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (bus.Done !== 1'b1 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_done"}, int'(bus.Done), 1);
            chk({tag, "_lat"}, cyc, e.lat);
            chk({tag, "_quot"}, int'(bus.Quotient), int'(e.q));
            chk({tag, "_rem"}, int'(bus.Remainder), int'(e.r));
            chk({tag, "_v"}, int'(bus.V), int'(e.v));
        end
    endtask

    task automatic run_op(input string tag, input logic [6:0] dvd, input logic [3:0] dvs);
        @(negedge CLK);
        bus.St       = 1'b1;
        bus.Dividend = dvd;
        bus.Divisor  = dvs;
        sb.push_back(model(dvd, dvs));
        @(negedge CLK);
        bus.St       = 1'b0;
        // Input changes after the sampling edge must not matter.
        bus.Dividend = 7'($urandom);
        bus.Divisor  = 4'($urandom);
        wait_check(tag);
        @(negedge CLK);
        chk({tag, "_pulse"}, int'(bus.Done), 0);
    endtask

    initial begin
        exp_t last;
        int   seen;
        bus.St       = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;

        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_quot", int'(bus.Quotient), 0);
        chk("rst_rem", int'(bus.Remainder), 0);
        chk("rst_v", int'(bus.V), 0);
        chk("rst_done", int'(bus.Done), 0);
        RST_N = 1'b1;

        run_op("q_pos", 7'b0010000, 4'b0100);
        run_op("q_neg", 7'b1101000, 4'b0110);
        run_op("rem_rnd", 7'b0001011, 4'b0011);
        run_op("neg_dvs", 7'b0001101, 4'b1100);
        run_op("ovf_pos", 7'b0100000, 4'b0100);
        run_op("div0", 7'b0000001, 4'b0000);
        run_op("ovf_neg", 7'b1100000, 4'b0100);
        run_op("min_min", 7'b1000000, 4'b1000);
        run_op("max_q", 7'b0111111, 4'b1000);
        run_op("neg_rem", 7'b1110101, 4'b0101);
        run_op("zero_q", 7'b1111111, 4'b0111);

        // Outputs hold in IDLE.
        last = model(7'b1110101, 4'b0101);
        last = model(7'b1111111, 4'b0111);
        repeat (3) @(negedge CLK);
        chk("hold_quot", int'(bus.Quotient), int'(last.q));
        chk("hold_rem", int'(bus.Remainder), int'(last.r));

        // St held high: back-to-back operations from IDLE.
        @(negedge CLK);
        bus.St       = 1'b1;
        bus.Dividend = 7'b0010000;
        bus.Divisor  = 4'b0100;
        sb.push_back(model(7'b0010000, 4'b0100));
        @(negedge CLK);
        bus.Dividend = 7'b1101000;
        bus.Divisor  = 4'b0110;
        sb.push_back(model(7'b1101000, 4'b0110));
        wait_check("b2b_a");
        @(negedge CLK);
        chk("b2b_idle_done", int'(bus.Done), 0);
        @(negedge CLK);
        bus.St = 1'b0;
        wait_check("b2b_b");
        @(negedge CLK);

        // Reset during DIV: no Done afterwards, outputs cleared.
        @(negedge CLK);
        bus.St       = 1'b1;
        bus.Dividend = 7'b0001011;
        bus.Divisor  = 4'b0011;
        @(negedge CLK);
        bus.St = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("mrst_quot", int'(bus.Quotient), 0);
        chk("mrst_rem", int'(bus.Remainder), 0);
        chk("mrst_v", int'(bus.V), 0);
        chk("mrst_done", int'(bus.Done), 0);
        seen = 0;
        repeat (8) begin
            @(negedge CLK);
            if (bus.Done === 1'b1) seen++;
        end
        chk("mrst_no_done", seen, 0);
        run_op("after_rst", 7'b0001011, 4'b0011);

        for (int i = 0; i < 12; i++)
            run_op("rand", 7'($urandom), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fraction_divider4.md
Name: fraction_divider4

Overview:
- Sequential signed-fraction divider. It is the inverse companion of the 4-bit fraction multiplier.
- It takes a 7-bit Q1.6 two's-complement dividend, in the same format as the multiplier's Product, and a 4-bit Q1.3 divisor.
- It returns a 4-bit Q1.3 quotient, a 4-bit remainder and an overflow flag.
- Uses the same St/Done start-complete handshake as the multiplier. Sign handling is sign-magnitude around a restoring divide core.

Parameters:
- None. Widths are fixed at 7/4/4.

Ports:
- CLK  input  1  Clock. Every register updates on the rising edge.
- RST_N  input  1  Reset. Synchronous, active-low.
- St  input  1  Start. Sampled only in IDLE.
- Dividend  input  7  Q1.6 two's-complement dividend (LSB = 2^-6). Sampled on the St edge.
- Divisor  input  4  Q1.3 two's-complement divisor (LSB = 2^-3). Sampled on the St edge.
- Quotient  output  4  Q1.3 two's-complement quotient.
- Remainder  output  4  Two's-complement remainder, LSB = 2^-6. Carries the dividend's sign.
- V  output  1  Overflow or divide-by-zero flag. Valid when Done=1.
- Done  output  1  One-cycle completion pulse.

Behaviour:
- Reset: RST_N=0 at an edge forces the following, regardless of state, including mid-divide:
  - state = IDLE
  - Quotient = 0000, Remainder = 0000, V = 0, Done = 0
  - internal registers cleared
- States: IDLE, LOAD, DIV, SIGN, DONE. Encoding is 3 bits.
- IDLE
  - St=1 → latch Dividend and Divisor, go to LOAD. St=0 → stay.
  - Outputs hold their last result.
- LOAD (1 cycle)
  - D = |Dividend|, 7 bits. -1.0 gives 64.
  - d = |Divisor|, 4 bits. -1.0 gives 8.
  - sq = Dividend[6] ^ Divisor[3]; sr = Dividend[6].
  - If d==0 or D >= 8·d: V=1, Quotient = sq ? 1000 : 0111, Remainder = 0000, go to DONE.
  - Otherwise: R = D, q = 000, count = 2, go to DIV.
- DIV (exactly 3 cycles, i = count = 2, 1, 0)
  - If R >= (d << i): R -= d << i, q[i] = 1. Otherwise q[i] = 0.
  - At i = 0 go to SIGN; otherwise decrement count.
  - R never exceeds 7 bits. Final R < d ≤ 8.
- SIGN (1 cycle)
  - Quotient = sq ? -{0,q} : {0,q}. A zero magnitude yields 0000, never negative zero.
  - Remainder = sr ? -{0,R[2:0]} : {0,R[2:0]}.
  - V = 0. Go to DONE.
- DONE (1 cycle)
  - Done = 1, then go to IDLE.
  - St is not sampled in DONE.
  - St held high keeps starting new operations back-to-back from IDLE.
- Latency, counted from the edge that samples St in IDLE:
  - Normal path: Done high during cycle 6 (LOAD, DIV×3, SIGN, DONE).
  - Overflow path: Done high during cycle 2.
- St is ignored in all states except IDLE. Input changes after the St edge have no effect.
- Quotient, Remainder and V change only in LOAD (overflow path) or SIGN. They are stable while Done=1 and until the next result.
- Done is a registered state decode and is glitch-free.

Optional Feature:
- Macro: FRAC_DIV_ROUND_EN
- Defined: in SIGN, if 2·R >= d and q != 111, the magnitude q is incremented before the sign is applied.
  - Round-half-away-from-zero on the magnitude.
  - q = 111 is left unrounded (no saturation change).
  - Remainder still reports the un-rounded R.
- Undefined: the quotient magnitude is truncated, i.e. floor of the magnitude.
- Latency is identical in both builds.

Test Plan:
- Dividend=0010000 (0.25), Divisor=0100 (0.5), St pulse → 6 cycles later Done=1, Quotient=0100, Remainder=0000, V=0.
- Dividend=1101000 (-0.375), Divisor=0110 (0.75) → Quotient=1100 (-0.5), Remainder=0000, V=0.
- Dividend=0001011 (11/64), Divisor=0011 → Quotient=0011, Remainder=0010, V=0. With FRAC_DIV_ROUND_EN: Quotient=0100, Remainder=0010.
- Dividend=0001101, Divisor=1100 (-0.5) → Quotient=1101, Remainder=0001. Rounding build gives the same result, since 2 < 4.
- Overflow and divide-by-zero:
  - Dividend=0100000, Divisor=0100 → Done 2 cycles after St, V=1, Quotient=0111, Remainder=0000.
  - Dividend=0000001, Divisor=0000 → V=1, Quotient=0111.
  - Dividend=1100000, Divisor=0100 → V=1, Quotient=1000.
- Reset mid-operation: start a divide, assert RST_N=0 for 1 edge during DIV → next cycle IDLE, all outputs 0, no Done pulse. A new St then completes normally with correct values.
